if_fetch_sequencer: RTL

Fetch-side sequencer at the far end of the decode control interface. It consumes `branch_taken`, `stop_if_out` and `swap_2_out` from decode, and owns the program counter. It runs the two-phase SWAP handshake by feeding the phase bit back to decode as `swap_2_in`, and it raises the pipeline flush on taken branches. It sits between the hazard unit and the IF/ID pipeline register.

---
 rtl/if_fetch_sequencer.sv | 74 +++++++
 1 files changed

// File: rtl/if_fetch_sequencer.sv
// Fetch-side sequencer: owns the PC, answers decode's two-phase SWAP handshake,
// and raises a one-cycle flush on taken branches. All outputs are registered.
module if_fetch_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int PC_STEP    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  stop_if_in,
  input  logic                  swap_req_in,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  instr_valid,
  output logic                  flush_out,
  output logic                  if_id_hold,
  output logic                  swap_2_in,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] SWAP_HOLD = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [0:0] state;
  logic       swap_req;
  logic       stall_inc;

  // SWAP request is only honoured from RUN; in SWAP_HOLD it is ignored.
  assign swap_req  = stop_if_in & swap_req_in & (state == RUN);
  // Branch redirects the PC, so it never counts as a stall even if frozen.
  assign stall_inc = ~branch_taken & (freeze | swap_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      flush_out   <= 1'b0;
      if_id_hold  <= 1'b0;
      swap_2_in   <= 1'b0;
      stall_count <= '0;
    end else begin
      flush_out <= 1'b0;
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + CNT_WIDTH'(1);

      if (branch_taken) begin
        pc_out      <= branch_addr;
        flush_out   <= 1'b1;
        instr_valid <= 1'b0;
        if_id_hold  <= 1'b0;
        swap_2_in   <= 1'b0;
        state       <= RUN;
      end else if (freeze) begin
        // hold everything, including the SWAP phase bit
      end else if (swap_req) begin
        if_id_hold <= 1'b1;
        swap_2_in  <= 1'b1;
        state      <= SWAP_HOLD;
      end else begin
        pc_out      <= pc_out + STEP;
        instr_valid <= 1'b1;
        if_id_hold  <= 1'b0;
        swap_2_in   <= 1'b0;
        state       <= RUN;
      end
    end
  end

endmodule
